// File: rtl/ov7670_pkg.sv
// Shared types for the camera -> core -> lenet frame sequencer.
package ov7670_pkg;

    localparam int SEQ_STATE_W = 3;

    typedef enum logic [SEQ_STATE_W-1:0] {
        ST_IDLE       = 3'd0,
        ST_CAPTURE    = 3'd1,
        ST_PROCESS    = 3'd2,
        ST_INFER_REQ  = 3'd3,
        ST_INFER_WAIT = 3'd4,
        ST_HOLD       = 3'd5
    } seq_state_t;

    // Stages that wait on an external block and are guarded by the stall timer.
    function automatic logic is_timed(input seq_state_t s);
        return (s == ST_CAPTURE) || (s == ST_PROCESS) || (s == ST_INFER_WAIT);
    endfunction

endpackage

// File: rtl/sw_debounce.sv
// Synchroniser plus level debouncer for one mechanical switch.
module sw_debounce #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 240000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sw_async,
    output logic sw_level
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    logic [SYNC_STAGES-1:0] sync_q;
    logic [CNT_W-1:0]       deb_cnt_q;
    logic                   level_q;
    logic                   synced;

    assign synced   = sync_q[SYNC_STAGES-1];
    assign sw_level = level_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q[0] <= sw_async;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    // Any sample that agrees with the accepted level restarts the stability run.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            deb_cnt_q <= '0;
            level_q   <= 1'b0;
        end else if (synced == level_q) begin
            deb_cnt_q <= '0;
        end else if (deb_cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            level_q   <= synced;
            deb_cnt_q <= '0;
        end else if (deb_cnt_q != '1) begin
            deb_cnt_q <= deb_cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/frame_sequencer.sv
// Per-frame scheduler: capture, core pass, lenet inference, with frame count and stall detection.
import ov7670_pkg::*;

module frame_sequencer #(
    parameter int DEBOUNCE_CYCLES = 240000,
    parameter int TIMEOUT_CYCLES  = 24000000,
    parameter int SYNC_STAGES     = 2
) (
    input  logic                   clk24,
    input  logic                   rst_n,
    input  logic                   sw_run,
    input  logic                   sw_pause,
    input  logic                   capture_end,
    input  logic                   core_end,
    input  logic                   lenet_ready,
    output logic                   capture_en,
    output logic                   core_start,
    output logic                   lenet_go,
    output logic [SEQ_STATE_W-1:0] seq_state,
    output logic [7:0]             frame_cnt,
    output logic                   timeout_err
);

    localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic run_lvl;
    logic pause_lvl;

    sw_debounce #(.SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_run_deb (
        .clk      (clk24),
        .rst_n    (rst_n),
        .sw_async (sw_run),
        .sw_level (run_lvl)
    );

    sw_debounce #(.SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_pause_deb (
        .clk      (clk24),
        .rst_n    (rst_n),
        .sw_async (sw_pause),
        .sw_level (pause_lvl)
    );

    logic [SYNC_STAGES-1:0] cap_sync_q;
    logic                   cap_prev_q;
    logic                   cap_edge;

    assign cap_edge = cap_sync_q[SYNC_STAGES-1] & ~cap_prev_q;

    always_ff @(posedge clk24 or negedge rst_n) begin
        if (!rst_n) begin
            cap_sync_q <= '0;
            cap_prev_q <= 1'b0;
        end else begin
            cap_sync_q[0] <= capture_end;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                cap_sync_q[i] <= cap_sync_q[i-1];
            end
            cap_prev_q <= cap_sync_q[SYNC_STAGES-1];
        end
    end

    seq_state_t       state_q, state_d;
    logic             busy_seen_q, busy_seen_d;
    logic             capture_en_q, capture_en_d;
    logic             core_start_q, core_start_d;
    logic             lenet_go_q, lenet_go_d;
    logic [TMO_W-1:0] tmo_cnt_q;
    logic [7:0]       frame_cnt_q;
    logic             timeout_err_q;
    logic             run_prev_q;
    logic             frame_done;
    logic             tmo_fire;
    logic             tmo_hit;

    assign tmo_hit = (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk24 or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            busy_seen_q  <= 1'b0;
            capture_en_q <= 1'b0;
            core_start_q <= 1'b0;
            lenet_go_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            busy_seen_q  <= busy_seen_d;
            capture_en_q <= capture_en_d;
            core_start_q <= core_start_d;
            lenet_go_q   <= lenet_go_d;
        end
    end

    // Completion events are tested before the stall timer so a late-but-valid event still counts.
    always_comb begin
        state_d     = state_q;
        busy_seen_d = busy_seen_q;
        frame_done  = 1'b0;
        tmo_fire    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (run_lvl && !pause_lvl) state_d = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                if (cap_edge) begin
                    state_d = ST_PROCESS;
                end else if (tmo_hit) begin
                    state_d  = ST_IDLE;
                    tmo_fire = 1'b1;
                end else if (!run_lvl) begin
                    state_d = ST_IDLE;
                end
            end
            ST_PROCESS: begin
                if (core_end) begin
                    state_d = ST_INFER_REQ;
                end else if (tmo_hit) begin
                    state_d  = ST_IDLE;
                    tmo_fire = 1'b1;
                end
            end
            ST_INFER_REQ: begin
                if (lenet_ready) state_d = ST_INFER_WAIT;
            end
            ST_INFER_WAIT: begin
                if (lenet_ready && busy_seen_q) begin
                    frame_done  = 1'b1;
                    busy_seen_d = 1'b0;
                    if (pause_lvl)    state_d = ST_HOLD;
                    else if (run_lvl) state_d = ST_CAPTURE;
                    else              state_d = ST_IDLE;
                end else if (tmo_hit) begin
                    state_d     = ST_IDLE;
                    tmo_fire    = 1'b1;
                    busy_seen_d = 1'b0;
                end else if (!lenet_ready) begin
                    busy_seen_d = 1'b1;
                end
            end
            ST_HOLD: begin
                if (!pause_lvl) state_d = run_lvl ? ST_CAPTURE : ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        capture_en_d = (state_d == ST_CAPTURE);
        core_start_d = (state_q == ST_CAPTURE) && (state_d == ST_PROCESS);
        lenet_go_d   = (state_q == ST_INFER_REQ) && (state_d == ST_INFER_WAIT);
    end

    always_ff @(posedge clk24 or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt_q <= '0;
        end else if ((state_d != state_q) || !is_timed(state_q)) begin
            tmo_cnt_q <= '0;
        end else if (tmo_cnt_q != '1) begin
            tmo_cnt_q <= tmo_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk24 or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt_q <= '0;
        end else if (frame_done) begin
            frame_cnt_q <= frame_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk24 or negedge rst_n) begin
        if (!rst_n) begin
            timeout_err_q <= 1'b0;
            run_prev_q    <= 1'b0;
        end else begin
            run_prev_q <= run_lvl;
            if (tmo_fire)                   timeout_err_q <= 1'b1;
            else if (run_prev_q && !run_lvl) timeout_err_q <= 1'b0;
        end
    end

    assign capture_en  = capture_en_q;
    assign core_start  = core_start_q;
    assign lenet_go    = lenet_go_q;
    assign seq_state   = state_q;
    assign frame_cnt   = frame_cnt_q;
    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_frame_sequencer.sv
// Directed-plus-random bench for frame_sequencer with a frame-level reference model.
module tb_frame_sequencer;

    logic       clk24 = 1'b0;
    logic       rst_n = 1'b0;
    logic       sw_run = 1'b0, sw_pause = 1'b0, capture_end = 1'b0;
    logic       core_end = 1'b0, lenet_ready = 1'b0;
    logic       capture_en, core_start, lenet_go, timeout_err;
    logic [2:0] seq_state;
    logic [7:0] frame_cnt;

    int tests = 0;
    int fails = 0;
    int cs_cnt = 0;
    int go_cnt = 0;
    int exp_frames = 0;

    frame_sequencer #(.DEBOUNCE_CYCLES(4), .TIMEOUT_CYCLES(100), .SYNC_STAGES(2)) dut (
        .clk24       (clk24),
        .rst_n       (rst_n),
        .sw_run      (sw_run),
        .sw_pause    (sw_pause),
        .capture_end (capture_end),
        .core_end    (core_end),
        .lenet_ready (lenet_ready),
        .capture_en  (capture_en),
        .core_start  (core_start),
        .lenet_go    (lenet_go),
        .seq_state   (seq_state),
        .frame_cnt   (frame_cnt),
        .timeout_err (timeout_err)
    );

    always #5 clk24 = ~clk24;

    always @(negedge clk24) begin
        if (core_start === 1'b1) cs_cnt++;
        if (lenet_go === 1'b1)   go_cnt++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk24);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wait_state(input string tag, input logic [2:0] exp, input int max_cycles);
        int n = 0;
        while (seq_state !== exp && n < max_cycles) begin
            tick();
            n++;
        end
        check(tag, {29'd0, seq_state}, {29'd0, exp});
    endtask

    // One complete frame starting in CAPTURE; drop_run lowers run so its debounced fall
    // coincides with the capture edge.
    task automatic run_frame(input bit pause_mid, input bit drop_run);
        int n;
        int g0;
        int c0;
        int exp_state;
        g0 = go_cnt;
        c0 = cs_cnt;
        if (drop_run) begin
            sw_run = 1'b0;
            repeat (4) tick();
        end else begin
            repeat ($urandom_range(0, 5)) tick();
        end
        capture_end = 1'b1;
        n = 0;
        while (core_start !== 1'b1 && n < 10) begin
            tick();
            n++;
        end
        check("core_start_latency", n, 3);
        check("process_state", {29'd0, seq_state}, 32'd2);
        capture_end = 1'b0;
        if (pause_mid) sw_pause = 1'b1;
        repeat ($urandom_range(8, 15)) tick();
        check("core_start_once", cs_cnt - c0, 1);
        core_end = 1'b1;
        tick();
        core_end = 1'b0;
        n = 0;
        while (lenet_go !== 1'b1 && n < 10) begin
            tick();
            n++;
        end
        check("lenet_go_seen", {31'd0, lenet_go}, 1);
        lenet_ready = 1'b0;
        repeat ($urandom_range(1, 12)) tick();
        lenet_ready = 1'b1;
        tick();
        exp_frames = (exp_frames + 1) % 256;
        exp_state  = pause_mid ? 5 : (sw_run ? 1 : 0);
        check("frame_cnt", {24'd0, frame_cnt}, exp_frames);
        check("lenet_go_once", go_cnt - g0, 1);
        check("state_after_done", {29'd0, seq_state}, exp_state);
        $display("[TB] frame %0d done, state %0d", exp_frames, seq_state);
    endtask

    initial begin
        int  n;
        int  guard;
        bit  bad;
        int  g0;

        // Reset held with inputs toggling
        repeat (20) begin
            {sw_run, sw_pause, capture_end, core_end, lenet_ready} = 5'($urandom);
            tick();
            check("reset_outputs", {17'd0, capture_en, core_start, lenet_go, seq_state, frame_cnt, timeout_err}, 0);
        end
        {sw_run, sw_pause, capture_end, core_end} = 4'b0000;
        lenet_ready = 1'b1;
        rst_n = 1'b1;
        repeat (10) tick();
        check("idle_after_reset", {29'd0, seq_state}, 0);

        // Normal frame
        sw_run = 1'b1;
        n = 0;
        while (capture_en !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check("run_accept_window", {31'd0, (n >= 6 && n <= 8)}, 1);
        check("capture_state", {29'd0, seq_state}, 1);
        run_frame(1'b0, 1'b0);

        // Pause during PROCESS, then release
        run_frame(1'b1, 1'b0);
        sw_pause = 1'b0;
        wait_state("hold_release", 3'd1, 20);

        // Stall in CAPTURE
        n = 0;
        while (seq_state === 3'd1 && n < 150) begin
            tick();
            n++;
        end
        check("timeout_cycles", n, 100);
        check("timeout_state", {29'd0, seq_state}, 0);
        check("timeout_err_set", {31'd0, timeout_err}, 1);
        check("timeout_capture_en", {31'd0, capture_en}, 0);
        check("timeout_frame_cnt", {24'd0, frame_cnt}, exp_frames);
        sw_run = 1'b0;
        n = 0;
        while (timeout_err !== 1'b0 && n < 20) begin
            tick();
            n++;
        end
        check("timeout_err_clear", {31'd0, timeout_err}, 0);
        wait_state("idle_after_clear", 3'd0, 20);
        $display("[TB] timeout handled, frame_cnt %0d", frame_cnt);

        // Two-cycle glitch on run
        bad = 1'b0;
        sw_run = 1'b1;
        tick();
        tick();
        sw_run = 1'b0;
        repeat (15) begin
            tick();
            if (capture_en !== 1'b0 || seq_state !== 3'd0) bad = 1'b1;
        end
        check("glitch_ignored", {31'd0, bad}, 0);

        // Capture edge coincides with run falling
        sw_run = 1'b1;
        wait_state("restart_capture", 3'd1, 20);
        run_frame(1'b0, 1'b1);

        // Wrap the frame counter
        sw_run = 1'b1;
        wait_state("wrap_capture", 3'd1, 20);
        guard = 0;
        while (exp_frames != 0 && guard < 300) begin
            run_frame(1'b0, 1'b0);
            guard++;
        end
        check("frame_cnt_wrap", {24'd0, frame_cnt}, 0);

        // Reset while waiting in INFER_REQ
        lenet_ready = 1'b0;
        capture_end = 1'b1;
        n = 0;
        while (core_start !== 1'b1 && n < 10) begin
            tick();
            n++;
        end
        capture_end = 1'b0;
        tick();
        core_end = 1'b1;
        tick();
        core_end = 1'b0;
        tick();
        check("infer_req_state", {29'd0, seq_state}, 3);
        rst_n = 1'b0;
        sw_run = 1'b0;
        tick();
        check("midframe_reset", {17'd0, capture_en, core_start, lenet_go, seq_state, frame_cnt, timeout_err}, 0);
        g0 = go_cnt;
        lenet_ready = 1'b1;
        rst_n = 1'b1;
        repeat (20) tick();
        check("no_go_after_reset", go_cnt - g0, 0);
        check("idle_after_midreset", {29'd0, seq_state}, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
